// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t   : mul/div occupancy FSM encoding (RUN = 0, BUSY = 1)
//   MD_CNT_W  : width of the mul/div down-counter. It covers the legal range
//               of MULDIV_CYCLES, which is 1..16.
package pipeline_hazard_controller_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MD_CNT_W = $clog2(16);

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter used for the hazard statistics.
//   clk   : rising-edge clock
//   clr_n : asynchronous active-low clear
//   inc   : count this cycle; the count holds once it reaches all-ones
//   count : current value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                  count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for a 5-stage RISC-V pipeline (IF ID EX MEM WB).
// It drives the per-stage register enables (hold) and flushes (bubble).
// Hazards are handled in this priority order:
//   1. data-memory wait
//   2. multi-cycle mul/div in EX
//   3. branch/jump redirect
//   4. load-use
// Ports:
//   clk, reset (async active-low)
//   id_*  : source registers of the ID instruction and their read flags
//   ex_*  : destination, load, mul/div and redirect status of EX
//   mem_req / mem_ready : data-memory handshake seen in MEM
//   *_enable / *_flush  : Mealy controls for PC and the stage registers
//   muldiv_busy         : FSM is in state BUSY
//   stall_count / flush_count : saturating statistics counters
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W    = 5,
  parameter int MULDIV_CYCLES = 4,
  parameter int STAT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_is_muldiv,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_enable,
  output logic                  if_id_enable,
  output logic                  if_id_flush,
  output logic                  id_ex_enable,
  output logic                  id_ex_flush,
  output logic                  ex_mem_enable,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_enable,
  output logic                  mem_wb_flush,
  output logic                  muldiv_busy,
  output logic [STAT_W-1:0]     stall_count,
  output logic [STAT_W-1:0]     flush_count
);

  // The entry cycle is the first stall cycle and the cycle that sees the
  // counter at zero is the release cycle. The counter therefore starts at
  // MULDIV_CYCLES-2.
  localparam logic [MD_CNT_W-1:0] CNT_INIT =
    (MULDIV_CYCLES > 1) ? MD_CNT_W'(MULDIV_CYCLES - 2) : '0;

  state_t              state, state_nxt;
  logic [MD_CNT_W-1:0] cnt, cnt_nxt;
  logic                mem_wait, md_entry, md_stall, load_use, flush_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    mem_wait = mem_req && !mem_ready;
    md_entry = (state == RUN) && ex_is_muldiv && (MULDIV_CYCLES > 1);
    md_stall = md_entry || (state == BUSY && cnt != '0);
    load_use = ex_mem_read && ex_rd != '0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

    state_nxt     = state;
    cnt_nxt       = cnt;
    flush_inc     = 1'b0;
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_enable = 1'b1;
    ex_mem_flush  = 1'b0;
    mem_wb_enable = 1'b1;
    mem_wb_flush  = 1'b0;

    if (!reset) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
    end else if (mem_wait) begin
      // Everything up to MEM holds, and WB takes a bubble. The FSM is frozen
      // because EX is frozen.
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_flush  = 1'b1;
    end else if (md_stall) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_ex_enable = 1'b0;
      ex_mem_flush = 1'b1;
      if (md_entry) begin
        state_nxt = BUSY;
        cnt_nxt   = CNT_INIT;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
    end else begin
      if (state == BUSY) state_nxt = RUN;
      // A redirect is counted only here. While a stall is active the redirect
      // stays asserted, so it is serviced once, when the stall releases.
      if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (load_use) begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_flush  = 1'b1;
      end
    end
  end

  assign muldiv_busy = (state == BUSY);

  sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (!pc_enable),
    .count (stall_count)
  );

  sat_counter #(.W(STAT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule
